product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream consumer of the 16x16 multiplier's 32-bit unsigned product stream.
//  Accumulates exactly ACC_LEN accepted products into one ACC_W-bit sum.
//  Presents the sum on a valid/ready output with a sticky overflow flag.
//  Provides the dot-product / MAC stage after the multiplier.
// PARAMETERS
//  PROD_W   32  product width; matches multiplier out[31:0]
//  ACC_W    40  accumulator/sum width; legal range PROD_W <= ACC_W <= 64
//  ACC_LEN  16  products per sum; legal range >= 1
// PORTS
//  clk       in   1        clock; all state updates on posedge
//  rst       in   1        reset; synchronous, active-high
//  clear     in   1        synchronous abort: discard partial/held sum, return to ACCUM
//  in_valid  in   1        in_prod valid
//  in_ready  out  1        block can accept in_prod this cycle
//  in_prod   in   PROD_W   unsigned product from multiplier
//  out_valid out  1        out_sum/out_ovf valid
//  out_ready in   1        downstream accepts result
//  out_sum   out  ACC_W    sum of ACC_LEN products, modulo 2^ACC_W
//  out_ovf   out  1        a carry out of ACC_W occurred during this sum
// BEHAVIOUR
//  Interface: one clock (clk); reset rst is synchronous and active-high.
//  Fire: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  Reset (rst=1 at posedge): state=ACCUM; acc=0; cnt=0; ovf=0; out_valid=0.
//   Also out_sum=0 and out_ovf=0. rst has priority over clear and all fires.
//  States: ACCUM, HOLD. State is registered, 1 bit.
//  ACCUM:
//   - in_ready=1; out_valid=0.
//   - in_fire: acc <= acc + zero-extended in_prod, evaluated in ACC_W+1 bits.
//   - In the same fire, ovf <= ovf | carry and cnt <= cnt+1.
//   - If in_fire and cnt==ACC_LEN-1:
//     - Load out_sum with the new acc and out_ovf with the new ovf.
//     - Reset acc=0, cnt=0, ovf=0; go to HOLD.
//   - Latency: out_valid rises the cycle after the ACC_LEN-th accept.
//  HOLD:
//   - out_valid=1; out_sum and out_ovf stay stable until out_fire.
//   - in_ready=out_ready (combinational pass-through). No bubble on back-to-back.
//   - out_fire without in_fire: go to ACCUM; out_valid=0 next cycle.
//   - out_fire with in_fire: the product starts the next sum (acc=in_prod, cnt=1).
//   - If ACC_LEN==1, that product immediately reloads out_sum; stay in HOLD.
//   - No out_ready: in_ready=0; input stalls and no product is dropped.
//  clear=1, no rst:
//   - Next state is ACCUM with acc=0, cnt=0, ovf=0, out_valid=0.
//   - Any in_prod presented that cycle is discarded, even if in_ready=1.
//   - A held result is discarded, even if out_ready=1.
//  Arithmetic: unsigned only. Wrap modulo 2^ACC_W.
//   out_ovf=1 iff any per-add carry out of bit ACC_W-1 occurred within the sum.
//  Counter: cnt width $clog2(ACC_LEN+1). Never exceeds ACC_LEN-1 in ACCUM.
//  in_valid may drop between products; gaps do not affect the sum.
//  out_valid, once high, holds until out_fire, clear or rst.
//   in_valid/in_prod are never required to be stable.
// TESTING
//  1. ACC_LEN=4, products 1,2,3,4, out_ready=1.
//     -> out_sum=10, out_ovf=0; out_valid high 1 cycle, the cycle after the 4th accept.
//  2. ACC_LEN=4, 8 back-to-back products 0xFFFF_FFFF, out_ready=1.
//     -> sums 0x3_FFFF_FFFC twice; in_ready never drops.
//  3. ACC_W=33, ACC_LEN=4, products 0xFFFF_FFFF x4.
//     -> out_sum=0x1_FFFF_FFFC (mod 2^33), out_ovf=1; next sum of 1s -> ovf=0.
//  4. Result held with out_ready=0 for 5 cycles while in_valid=1.
//     -> in_ready=0 and out_sum stable; on out_ready=1 the held product is
//        accepted the same cycle and counts toward the next sum.
//  5. clear after 2 of 4 products, then 1,1,1,1.
//     -> out_sum=4.
//  6. rst asserted mid-sum and in HOLD.
//     -> next cycle out_valid=0, in_ready=1; subsequent 4 products sum from 0.

Source files
------------

// File: rtl/product_accumulator.sv
// MAC stage behind the 16x16 multiplier: sums ACC_LEN unsigned products into
// one ACC_W-bit result and offers it on a valid/ready port with a sticky overflow flag.
module product_accumulator #(
  parameter int PROD_W  = 32,
  parameter int ACC_W   = 40,
  parameter int ACC_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = $clog2(ACC_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [ACC_W-1:0]  acc, acc_d, sum_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              ovf, ovf_d, sum_ovf_d;
  logic [ACC_W:0]    add;
  logic              in_fire, out_fire;

  // While holding, an input is only taken when the result leaves the same cycle.
  assign in_ready  = (state == ACCUM) | out_ready;
  assign out_valid = (state == HOLD);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Extra top bit captures the carry out of the ACC_W-bit accumulator.
  assign add = {1'b0, acc} + (ACC_W + 1)'(in_prod);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= ACCUM;
    else     state <= state_d;
  end

  // acc/cnt/ovf are always zero in HOLD, so the same add path starts the next sum.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d   = state;
    acc_d     = acc;
    cnt_d     = cnt;
    ovf_d     = ovf;
    sum_d     = out_sum;
    sum_ovf_d = out_ovf;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (out_fire) state_d = ACCUM;
      if (in_fire) begin
        if (cnt == LAST) begin
          sum_d     = add[ACC_W-1:0];
          sum_ovf_d = ovf | add[ACC_W];
          acc_d     = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = HOLD;
        end else begin
          acc_d = add[ACC_W-1:0];
          cnt_d = cnt + CNT_W'(1);
          ovf_d = ovf | add[ACC_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      acc     <= acc_d;
      cnt     <= cnt_d;
      ovf     <= ovf_d;
      out_sum <= sum_d;
      out_ovf <= sum_ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (40/4, 33/4, 32/1) on shared stimulus,
// checked by a directed table, hand sequences and a running-total reference model.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready;
  logic [31:0] in_prod;

  logic        ir0, ir1, ir2, ov0, ov1, ov2, ovf0, ovf1, ovf2;
  logic [39:0] sum0;
  logic [32:0] sum1;
  logic [31:0] sum2;

  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(32), .ACC_W(40), .ACC_LEN(4)) u_d0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir0),
    .in_prod(in_prod), .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0), .out_ovf(ovf0));
  product_accumulator #(.PROD_W(32), .ACC_W(33), .ACC_LEN(4)) u_d1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir1),
    .in_prod(in_prod), .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1), .out_ovf(ovf1));
  product_accumulator #(.PROD_W(32), .ACC_W(32), .ACC_LEN(1)) u_d2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
    .in_prod(in_prod), .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2), .out_ovf(ovf2));

  logic [63:0] sum_a [3];
  logic        ov_a  [3];
  logic        ir_a  [3];
  logic        ovf_a [3];
  assign sum_a[0] = 64'(sum0);
  assign sum_a[1] = 64'(sum1);
  assign sum_a[2] = 64'(sum2);
  assign ov_a[0] = ov0;   assign ov_a[1] = ov1;   assign ov_a[2] = ov2;
  assign ir_a[0] = ir0;   assign ir_a[1] = ir1;   assign ir_a[2] = ir2;
  assign ovf_a[0] = ovf0; assign ovf_a[1] = ovf1; assign ovf_a[2] = ovf2;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: true-arithmetic running total per instance; a result is
  // the total mod 2^W, overflow iff the total reached 2^W.
  int              len_v [3] = '{4, 4, 1};
  int              w_v   [3] = '{40, 33, 32};
  bit              m_valid = 1'b0;
  bit              m_hold [3];
  longint unsigned m_sum  [3];
  bit              m_ovf  [3];
  longint unsigned m_tot  [3];
  int              m_cnt  [3];

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (m_valid) begin
        check($sformatf("d%0d_out_valid", d), 64'(ov_a[d]), 64'(m_hold[d]));
        check($sformatf("d%0d_in_ready", d), 64'(ir_a[d]), 64'(!m_hold[d] || out_ready));
        if (m_hold[d]) begin
          check($sformatf("d%0d_out_sum", d), sum_a[d], m_sum[d]);
          check($sformatf("d%0d_out_ovf", d), 64'(ovf_a[d]), 64'(m_ovf[d]));
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_hold[d] = 1'b0; m_tot[d] = 0; m_cnt[d] = 0; m_sum[d] = 0; m_ovf[d] = 1'b0;
      end else if (clear) begin
        m_hold[d] = 1'b0; m_tot[d] = 0; m_cnt[d] = 0;
      end else begin
        bit rdy;
        rdy = !m_hold[d] || out_ready;
        if (m_hold[d] && out_ready) m_hold[d] = 1'b0;
        if (in_valid && rdy) begin
          m_tot[d] += longint'(in_prod);
          m_cnt[d]++;
          if (m_cnt[d] == len_v[d]) begin
            m_sum[d]  = m_tot[d] & ((64'd1 << w_v[d]) - 64'd1);
            m_ovf[d]  = (m_tot[d] >> w_v[d]) != 0;
            m_hold[d] = 1'b1;
            m_tot[d]  = 0;
            m_cnt[d]  = 0;
          end
        end
      end
    end
    if (rst) m_valid = 1'b1;
  endtask

  task automatic drive(input bit r, input bit c, input bit iv, input logic [31:0] p, input bit ordy);
    rst = r; clear = c; in_valid = iv; in_prod = p; out_ready = ordy;
  endtask

  task automatic settle();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit r, input bit c, input bit iv, input logic [31:0] p, input bit ordy);
    drive(r, c, iv, p, ordy);
    settle();
    adv();
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] prod;
    bit          ov;
    logic [39:0] sum0;
    bit          ovf1;
    logic [32:0] sum1;
  } vec_t;

  vec_t tbl [16];

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 40'd0, 1'b0, 33'd0};
    tbl[0]  = '{1'b1, 32'd1, 1'b0, 40'd0, 1'b0, 33'd0};
    tbl[1]  = '{1'b1, 32'd2, 1'b0, 40'd0, 1'b0, 33'd0};
    tbl[2]  = '{1'b1, 32'd3, 1'b0, 40'd0, 1'b0, 33'd0};
    tbl[3]  = '{1'b1, 32'd4, 1'b0, 40'd0, 1'b0, 33'd0};
    tbl[4]  = '{1'b0, 32'd0, 1'b1, 40'd10, 1'b0, 33'd10};
    tbl[5]  = '{1'b0, 32'd0, 1'b0, 40'd0, 1'b0, 33'd0};
    tbl[10] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 40'h3_FFFF_FFFC, 1'b1, 33'h1_FFFF_FFFC};
    tbl[14] = '{1'b0, 32'd0, 1'b1, 40'h3_FFFF_FFFC, 1'b1, 33'h1_FFFF_FFFC};
    tbl[15] = '{1'b0, 32'd0, 1'b0, 40'd0, 1'b0, 33'd0};

    // Reset, then confirm the idle state including zeroed result registers.
    step(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    check("rst_out_valid", 64'(ov0), 64'd0);
    check("rst_in_ready", 64'(ir0), 64'd1);
    check("rst_out_sum0", 64'(sum0), 64'd0);
    check("rst_out_sum1", 64'(sum1), 64'd0);
    check("rst_out_ovf", 64'({ovf0, ovf1, ovf2}), 64'd0);
    adv();

    // Sum of 1..4, then two back-to-back sums of all-ones products.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, tbl[i].iv, tbl[i].prod, 1);
      settle();
      check($sformatf("tbl%0d_out_valid", i), 64'(ov0), 64'(tbl[i].ov));
      check($sformatf("tbl%0d_in_ready", i), 64'(ir0), 64'd1);
      check($sformatf("tbl%0d_d1_out_valid", i), 64'(ov1), 64'(tbl[i].ov));
      if (tbl[i].ov) begin
        check($sformatf("tbl%0d_sum0", i), 64'(sum0), 64'(tbl[i].sum0));
        check($sformatf("tbl%0d_ovf0", i), 64'(ovf0), 64'd0);
        check($sformatf("tbl%0d_sum1", i), 64'(sum1), 64'(tbl[i].sum1));
        check($sformatf("tbl%0d_ovf1", i), 64'(ovf1), 64'(tbl[i].ovf1));
      end
      adv();
    end

    // Back-pressure: result held 5 cycles while a product waits, then taken.
    step(0, 0, 1, 5, 1); step(0, 0, 1, 6, 1); step(0, 0, 1, 7, 1); step(0, 0, 1, 8, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 100, 0);
      settle();
      check($sformatf("stall%0d_in_ready", i), 64'(ir0), 64'd0);
      check($sformatf("stall%0d_out_sum", i), 64'(sum0), 64'd26);
      adv();
    end
    drive(0, 0, 1, 100, 1);
    settle();
    check("release_in_ready", 64'(ir0), 64'd1);
    adv();
    drive(0, 0, 1, 1, 1);
    settle();
    check("release_next_out_valid", 64'(ov0), 64'd0);
    adv();
    step(0, 0, 1, 1, 1); step(0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    check("carry_in_sum", 64'(sum0), 64'd103);
    adv();

    // Clear after two products discards them and the product offered with it.
    step(0, 0, 1, 9, 1); step(0, 0, 1, 9, 1);
    step(0, 1, 1, 50, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    check("clear_out_valid", 64'(ov0), 64'd1);
    check("clear_out_sum", 64'(sum0), 64'd4);
    check("ones_ovf1", 64'(ovf1), 64'd0);
    adv();

    // Clear while holding drops the result even with out_ready high.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2, 1);
    step(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    check("clear_hold_out_valid", 64'(ov0), 64'd0);
    adv();

    // Reset while holding, then reset mid-sum; next sum starts from zero.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    settle();
    check("rst_hold_out_valid", 64'(ov0), 64'd0);
    check("rst_hold_in_ready", 64'(ir0), 64'd1);
    adv();
    step(0, 0, 1, 7, 1); step(0, 0, 1, 7, 1);
    step(1, 0, 1, 7, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2, 1);
    drive(0, 0, 0, 0, 1);
    settle();
    check("rst_mid_out_sum", 64'(sum0), 64'd8);
    adv();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7), p, ($urandom_range(0, 9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
